m68k_bus_sequencer: RTL and testbench
=====================================

Name: m68k_bus_sequencer

Overview:
Registered bus-cycle controller for the 68000 glue logic. It replaces the always-asserted DTACK with a per-cycle state machine that does five things:
- decodes ROM/RAM/device space;
- inserts per-region wait states;
- sequences FT245-style serial strobes (_rd/wr) against _rdf/_txe;
- answers interrupt-acknowledge with autovector (_vpa);
- raises bus error on timeout.
A single-step mode holds each cycle's acknowledge until a debounced step button edge, giving clean instruction stepping without toggling _halt/_reset.

Parameters:
ROM_WS, 2, wait cycles before _dtack for ROM accesses
RAM_WS, 0, wait cycles before _dtack for RAM accesses
FT_PULSE, 3, cycles _rd/wr strobe held before _dtack (FT245 minimum strobe width)
TIMEOUT, 64, cycles from decode with no acknowledge before _berr asserts
CNT_W, 8, width of the shared wait/timeout counter; must hold TIMEOUT

Ports:
clk  in  1  system clock, same as CPU clock; all inputs sampled on its rising edge
reset  in  1  asynchronous, active-high reset
addr  in  8  CPU address bits [19:12]
_as  in  1  address strobe, active low
_ds  in  1  data strobe, active low
rw  in  1  1 = read, 0 = write
fc0  in  1  function code bit 0
fc1  in  1  function code bit 1; fc0&fc1 = interrupt acknowledge
_txe  in  1  FT245 transmit-empty, low = may write
_rdf  in  1  FT245 receive-full, low = data available
step_mode  in  1  1 = single-step acknowledge gating enabled
step_btn  in  1  asynchronous step button, active high
_dtack  out  1  data transfer acknowledge, active low
_vpa  out  1  valid peripheral address (autovector), active low
_berr  out  1  bus error, active low
_rd  out  1  FT245 read strobe, active low
wr  out  1  FT245 write strobe, active high
_ceram  out  1  RAM chip enable, active low
_cerom  out  1  ROM chip enable, active low
busy  out  1  1 while the sequencer is in any state other than IDLE

Behaviour:
- Reset (async): state IDLE, counter 0, all outputs at their inactive levels.
  - _dtack=1, _vpa=1, _berr=1, _rd=1, wr=0, _ceram=1, _cerom=1, busy=0.
- Decode, sampled in IDLE on the first edge where _as=0 (cycle C0):
  - IACK: fc0&fc1.
  - DEV: addr[19:15]=01111; sub-function = addr[14:13] (00 serial-in, 01 serial-out, 10 status, 11 LED).
  - RAM: addr[19]=1.
  - ROM: everything else.
- States: IDLE, WAIT, FT_WAIT, FT_STROBE, STEP, ACK, BERR, HOLD.
- IDLE -> on _as=0:
  - IACK -> ACK with _vpa path;
  - RAM/ROM -> WAIT, counter loaded with WS;
  - serial-in/out -> FT_WAIT;
  - status/LED -> ACK.
- Chip enables:
  - _ceram=0 from C0+1 through the whole RAM cycle.
  - _cerom=0 likewise for ROM.
  - Never both 0 at once; neither is 0 for IACK or DEV cycles.
- WAIT: decrement each cycle; at 0 -> STEP if step_mode=1, else ACK. WS=0 goes straight to ACK; RAM _dtack is low after edge C0+1.
- FT_WAIT, serial-in: wait for _rdf=0. Serial-out: wait for _txe=0 and _ds=0. Then -> FT_STROBE.
- FT_STROBE:
  - Serial-in: _rd=0. Serial-out: wr=1.
  - Strobe held for FT_PULSE cycles, then -> STEP/ACK.
  - _rd stays 0 through ACK until HOLD exit, so read data stays valid. wr drops on entry to ACK.
- STEP: step_btn passes a 2-flop synchroniser, then rising-edge detect. The edge -> ACK. A press arriving before STEP is entered is ignored.
- ACK: _dtack=0, or _vpa=0 for IACK (with _dtack=1). -> HOLD.
- HOLD: keep the acknowledge, chip enable and _rd asserted until _as=1. Then all outputs inactive on that same edge -> IDLE, ready for a new _as on the next edge.
- Timeout:
  - A separate count runs from C0 in WAIT/FT_WAIT/FT_STROBE. It does not run in STEP.
  - Reaching TIMEOUT -> BERR: _berr=0, strobes released, _dtack=1, held until _as=1 -> IDLE.
  - A timeout and a ready condition on the same edge: ready wins.
- Early _as=1 (abort) in any state: all outputs inactive on the next edge -> IDLE. No _dtack pulse leaks out.
- _berr and _dtack are never asserted together. _vpa and _dtack are never asserted together.
- Reset mid-cycle: outputs drop immediately and asynchronously.

Test Plan:
- RAM read, addr=0x80, RAM_WS=0: _as low at C0 -> _ceram=0 and _dtack=0 after C0+1; _as high -> _dtack=1 and _ceram=1 next edge, busy=0.
- ROM read, addr=0x00, ROM_WS=2 -> _dtack=0 after edge C0+3; _ceram stays 1 throughout.
- Serial-in, addr=0x78, with _rdf=1 for 5 cycles then 0 -> _rd=0 for 3 cycles before _dtack=0; _rd held until _as=1.
- Serial-out, addr=0x7A, rw=0, _txe=1 permanently -> _berr=0 at C0+64, wr never 1, _dtack never 0.
- IACK, fc0=fc1=1 -> _vpa=0 after C0+1 and _dtack=1; released when _as=1.
- step_mode=1, RAM read -> cycle parks in STEP with no _berr after 200 cycles; one step_btn pulse -> _dtack=0 within 4 cycles. Also assert reset during STEP -> all outputs inactive immediately.

Source files
------------

// File: rtl/m68k_bus_sequencer.sv
// m68k_bus_sequencer: per-cycle bus controller for 68000 glue logic.
// It decodes ROM/RAM/device space, inserts per-region wait states, sequences
// FT245 strobes, answers IACK with an autovector and raises bus error on timeout.
// A single-step mode holds each acknowledge until a step-button edge.
//
// Ports:
//   i_clk, i_reset            clock, async active-high reset
//   i_addr[7:0]               CPU address bits [19:12]
//   i_as_n, i_ds_n, i_rw      address strobe, data strobe, read/write
//   i_fc0, i_fc1              function code (both high = interrupt acknowledge)
//   i_txe_n, i_rdf_n          FT245 transmit-empty / receive-full flags
//   i_step_mode, i_step_btn   single-step enable, async step button
//   o_dtack_n, o_vpa_n        acknowledge / autovector
//   o_berr_n                  bus error
//   o_rd_n, o_wr              FT245 read / write strobes
//   o_ceram_n, o_cerom_n      chip enables
//   o_busy                    sequencer not idle
module m68k_bus_sequencer #(
   parameter int unsigned ROM_WS   = 2,
   parameter int unsigned RAM_WS   = 0,
   parameter int unsigned FT_PULSE = 3,
   parameter int unsigned TIMEOUT  = 64,
   parameter int unsigned CNT_W    = 8
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [7:0] i_addr,
   input  logic       i_as_n,
   input  logic       i_ds_n,
   input  logic       i_rw,
   input  logic       i_fc0,
   input  logic       i_fc1,
   input  logic       i_txe_n,
   input  logic       i_rdf_n,
   input  logic       i_step_mode,
   input  logic       i_step_btn,
   output logic       o_dtack_n,
   output logic       o_vpa_n,
   output logic       o_berr_n,
   output logic       o_rd_n,
   output logic       o_wr,
   output logic       o_ceram_n,
   output logic       o_cerom_n,
   output logic       o_busy
);

   typedef enum logic [2:0] {
      StIdle, StWait, StFtWait, StFtStrobe, StStep, StAck, StBerr, StHold
   } state_e;

   typedef enum logic [2:0] {
      RgnRom, RgnRam, RgnIack, RgnSin, RgnSout, RgnReg
   } rgn_e;

   // Counters load N-1 so that the exit test is a compare against zero.
   localparam logic [CNT_W-1:0] RomLd   = CNT_W'(ROM_WS - 1);
   localparam logic [CNT_W-1:0] RamLd   = CNT_W'(RAM_WS - 1);
   localparam logic [CNT_W-1:0] FtLd    = CNT_W'(FT_PULSE - 1);
   localparam logic [CNT_W-1:0] TmoLast = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] One     = CNT_W'(1);

   state_e           r_state;
   rgn_e             r_rgn;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_tmo;
   logic             r_dtack_n, r_vpa_n, r_berr_n, r_rd_n, r_wr, r_ceram_n, r_cerom_n;
   logic             r_btn_s1, r_btn_s2, r_btn_s3;

   rgn_e   w_rgn;
   state_e w_after;
   logic   w_ft_ready;
   logic   w_tmo_hit;
   logic   w_step_edge;
   logic   w_unused;

   // Address bit 12 and rw do not affect sequencing.
   assign w_unused = ^{i_addr[0], i_rw};

   always_comb begin
      w_rgn = RgnRom;
      if (i_fc0 && i_fc1) begin
         w_rgn = RgnIack;
      end else if (i_addr[7:3] == 5'b01111) begin
         case (i_addr[2:1])
            2'b00:   w_rgn = RgnSin;
            2'b01:   w_rgn = RgnSout;
            default: w_rgn = RgnReg;
         endcase
      end else if (i_addr[7]) begin
         w_rgn = RgnRam;
      end
   end

   assign w_after     = i_step_mode ? StStep : StAck;
   assign w_ft_ready  = (r_rgn == RgnSin) ? !i_rdf_n : (!i_txe_n && !i_ds_n);
   assign w_tmo_hit   = (r_tmo == TmoLast);
   assign w_step_edge = r_btn_s2 && !r_btn_s3;

   // Step button: 2-flop synchroniser plus one flop for edge detection.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_btn_s1 <= 1'b0;
         r_btn_s2 <= 1'b0;
         r_btn_s3 <= 1'b0;
      end else begin
         r_btn_s1 <= i_step_btn;
         r_btn_s2 <= r_btn_s1;
         r_btn_s3 <= r_btn_s2;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= StIdle;
         r_rgn     <= RgnRom;
         r_cnt     <= '0;
         r_tmo     <= '0;
         r_dtack_n <= 1'b1;
         r_vpa_n   <= 1'b1;
         r_berr_n  <= 1'b1;
         r_rd_n    <= 1'b1;
         r_wr      <= 1'b0;
         r_ceram_n <= 1'b1;
         r_cerom_n <= 1'b1;
      end else if (r_state != StIdle && i_as_n) begin
         // Normal end of HOLD/BERR or an abort: release everything on this edge.
         r_state   <= StIdle;
         r_dtack_n <= 1'b1;
         r_vpa_n   <= 1'b1;
         r_berr_n  <= 1'b1;
         r_rd_n    <= 1'b1;
         r_wr      <= 1'b0;
         r_ceram_n <= 1'b1;
         r_cerom_n <= 1'b1;
      end else begin
         if (r_state != StIdle && r_state != StBerr) begin
            r_ceram_n <= (r_rgn != RgnRam);
            r_cerom_n <= (r_rgn != RgnRom);
         end
         case (r_state)
            StIdle: begin
               if (!i_as_n) begin
                  r_rgn <= w_rgn;
                  r_tmo <= '0;
                  case (w_rgn)
                     RgnRam: begin
                        if (RAM_WS == 0) begin
                           r_state <= w_after;
                        end else begin
                           r_state <= StWait;
                           r_cnt   <= RamLd;
                        end
                     end
                     RgnRom: begin
                        if (ROM_WS == 0) begin
                           r_state <= w_after;
                        end else begin
                           r_state <= StWait;
                           r_cnt   <= RomLd;
                        end
                     end
                     RgnSin, RgnSout: r_state <= StFtWait;
                     default:         r_state <= StAck;
                  endcase
               end
            end
            StWait: begin
               r_tmo <= r_tmo + One;
               // Ready is tested first so it wins over a coincident timeout.
               if (r_cnt == '0) begin
                  r_state <= w_after;
               end else if (w_tmo_hit) begin
                  r_state   <= StBerr;
                  r_berr_n  <= 1'b0;
                  r_ceram_n <= 1'b1;
                  r_cerom_n <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - One;
               end
            end
            StFtWait: begin
               r_tmo <= r_tmo + One;
               if (w_ft_ready) begin
                  r_state <= StFtStrobe;
                  r_cnt   <= FtLd;
               end else if (w_tmo_hit) begin
                  r_state  <= StBerr;
                  r_berr_n <= 1'b0;
               end
            end
            StFtStrobe: begin
               r_tmo  <= r_tmo + One;
               r_rd_n <= (r_rgn != RgnSin);
               r_wr   <= (r_rgn == RgnSout);
               if (r_cnt == '0) begin
                  r_state <= w_after;
               end else if (w_tmo_hit) begin
                  r_state  <= StBerr;
                  r_berr_n <= 1'b0;
                  r_rd_n   <= 1'b1;
                  r_wr     <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - One;
               end
            end
            StStep: begin
               if (w_step_edge) begin
                  r_state <= StAck;
               end
            end
            StAck: begin
               if (r_rgn == RgnIack) begin
                  r_vpa_n <= 1'b0;
               end else begin
                  r_dtack_n <= 1'b0;
               end
               // Write strobe ends with the acknowledge; read strobe is held
               // through HOLD so the FIFO keeps driving data.
               r_wr    <= 1'b0;
               r_state <= StHold;
            end
            StHold, StBerr: begin
               r_state <= r_state;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_dtack_n = r_dtack_n;
   assign o_vpa_n   = r_vpa_n;
   assign o_berr_n  = r_berr_n;
   assign o_rd_n    = r_rd_n;
   assign o_wr      = r_wr;
   assign o_ceram_n = r_ceram_n;
   assign o_cerom_n = r_cerom_n;
   assign o_busy    = (r_state != StIdle);

endmodule

// File: tb/tb_m68k_bus_sequencer.sv
// Bench for m68k_bus_sequencer: each scenario pushes its expected results to a
// scoreboard queue as stimulus is driven, then pops and compares them as the
// DUT responds. Bus-protocol invariants are checked on every sampled cycle.
module tb_m68k_bus_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] addr;
   logic       as_n, ds_n, rw, fc0, fc1, txe_n, rdf_n, step_mode, step_btn;
   logic       dtack_n, vpa_n, berr_n, rd_n, wr, ceram_n, cerom_n, busy;

   int n_total = 0;
   int n_bad   = 0;
   int n_ceram_lo, n_cerom_lo, n_wr_hi, n_rd_lo, n_berr_lo, n_dtack_lo;
   int lat;

   typedef struct {
      string tag;
      int    val;
   } exp_t;
   exp_t sb_q[$];

   m68k_bus_sequencer #(
      .ROM_WS  (2),
      .RAM_WS  (0),
      .FT_PULSE(3),
      .TIMEOUT (64),
      .CNT_W   (8)
   ) u_dut (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_addr     (addr),
      .i_as_n     (as_n),
      .i_ds_n     (ds_n),
      .i_rw       (rw),
      .i_fc0      (fc0),
      .i_fc1      (fc1),
      .i_txe_n    (txe_n),
      .i_rdf_n    (rdf_n),
      .i_step_mode(step_mode),
      .i_step_btn (step_btn),
      .o_dtack_n  (dtack_n),
      .o_vpa_n    (vpa_n),
      .o_berr_n   (berr_n),
      .o_rd_n     (rd_n),
      .o_wr       (wr),
      .o_ceram_n  (ceram_n),
      .o_cerom_n  (cerom_n),
      .o_busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input int want);
      n_total++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, want);
      end
   endtask

   task automatic sb_push(input string tag, input int val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb_q.push_back(e);
   endtask

   task automatic sb_check(input logic [31:0] got);
      exp_t e;
      check_val("sb_has_entry", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_val(e.tag, got, e.val);
      end
   endtask

   task automatic clr_mon();
      n_ceram_lo = 0; n_cerom_lo = 0; n_wr_hi = 0;
      n_rd_lo    = 0; n_berr_lo  = 0; n_dtack_lo = 0;
   endtask

   // One clock: advance past the rising edge and sample on the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      if (!ceram_n) n_ceram_lo++;
      if (!cerom_n) n_cerom_lo++;
      if (wr)       n_wr_hi++;
      if (!rd_n)    n_rd_lo++;
      if (!berr_n)  n_berr_lo++;
      if (!dtack_n) n_dtack_lo++;
      check_val("inv_berr_dtack", !berr_n && !dtack_n, 0);
      check_val("inv_vpa_dtack", !vpa_n && !dtack_n, 0);
      check_val("inv_ce_both", !ceram_n && !cerom_n, 0);
   endtask

   // Ticks until an acknowledge appears; lat = ticks taken, -1 if none in max.
   task automatic wait_ack(input int max, output int l);
      int i = 0;
      l = -1;
      while (l < 0 && i < max) begin
         tick();
         i++;
         if (!dtack_n || !vpa_n) l = i;
      end
   endtask

   task automatic start(input logic [7:0] a, input logic r, input logic f0, input logic f1);
      addr = a; rw = r; fc0 = f0; fc1 = f1; ds_n = 1'b0; as_n = 1'b0;
   endtask

   task automatic end_cycle();
      as_n = 1'b1;
      ds_n = 1'b1;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; addr = 8'h00; as_n = 1'b1; ds_n = 1'b1; rw = 1'b1;
      fc0 = 1'b1; fc1 = 1'b0; txe_n = 1'b1; rdf_n = 1'b1;
      step_mode = 1'b0; step_btn = 1'b0;
      clr_mon();
      tick();
      tick();
      check_val("rst_dtack", dtack_n, 1);
      check_val("rst_vpa", vpa_n, 1);
      check_val("rst_berr", berr_n, 1);
      check_val("rst_rd", rd_n, 1);
      check_val("rst_wr", wr, 0);
      check_val("rst_ceram", ceram_n, 1);
      check_val("rst_cerom", cerom_n, 1);
      check_val("rst_busy", busy, 0);
      reset = 1'b0;
      tick();

      // RAM read, zero wait states.
      sb_push("ram_ce_at_c0", 1);
      sb_push("ram_lat", 2);
      sb_push("ram_ce_at_ack", 0);
      sb_push("ram_rom_ce_lo", 0);
      sb_push("ram_rel_dtack", 1);
      sb_push("ram_rel_ce", 1);
      sb_push("ram_rel_busy", 0);
      start(8'h80, 1'b1, 1'b1, 1'b0);
      clr_mon();
      tick();
      sb_check(ceram_n);
      wait_ack(8, lat);
      sb_check(lat + 1);
      sb_check(ceram_n);
      sb_check(n_cerom_lo);
      end_cycle();
      sb_check(dtack_n);
      sb_check(ceram_n);
      sb_check(busy);

      // ROM read, two wait states.
      sb_push("rom_lat", 4);
      sb_push("rom_cerom_at_ack", 0);
      sb_push("rom_ceram_lo", 0);
      sb_push("rom_rel_cerom", 1);
      start(8'h00, 1'b1, 1'b1, 1'b0);
      clr_mon();
      wait_ack(10, lat);
      sb_check(lat);
      sb_check(cerom_n);
      sb_check(n_ceram_lo);
      end_cycle();
      sb_check(cerom_n);

      // Serial-in: FIFO empty for 5 cycles, then data available.
      sb_push("sin_rd_idle", 1);
      sb_push("sin_lat", 5);
      sb_push("sin_rd_before_ack", 3);
      sb_push("sin_rd_held", 0);
      sb_push("sin_dtack_held", 0);
      sb_push("sin_rel_rd", 1);
      sb_push("sin_rel_busy", 0);
      start(8'h78, 1'b1, 1'b1, 1'b0);
      repeat (5) tick();
      sb_check(rd_n);
      rdf_n = 1'b0;
      clr_mon();
      wait_ack(10, lat);
      sb_check(lat);
      sb_check(n_rd_lo - 1);
      repeat (3) tick();
      sb_check(rd_n);
      sb_check(dtack_n);
      end_cycle();
      rdf_n = 1'b1;
      sb_check(rd_n);
      sb_check(busy);

      // Serial-out with FIFO never ready: bus error at C0+64.
      sb_push("tmo_berr_c63", 1);
      sb_push("tmo_berr_c64", 0);
      sb_push("tmo_wr_hi", 0);
      sb_push("tmo_dtack_lo", 0);
      sb_push("tmo_berr_held", 0);
      sb_push("tmo_dtack_held", 1);
      sb_push("tmo_rel_berr", 1);
      sb_push("tmo_rel_busy", 0);
      start(8'h7A, 1'b0, 1'b1, 1'b0);
      clr_mon();
      repeat (64) tick();
      sb_check(berr_n);
      tick();
      sb_check(berr_n);
      sb_check(n_wr_hi);
      sb_check(n_dtack_lo);
      repeat (3) tick();
      sb_check(berr_n);
      sb_check(dtack_n);
      end_cycle();
      sb_check(berr_n);
      sb_check(busy);

      // Serial-out with FIFO ready: 3-cycle write strobe then acknowledge.
      txe_n = 1'b0;
      sb_push("sout_lat", 6);
      sb_push("sout_wr_hi", 3);
      sb_push("sout_wr_at_ack", 0);
      sb_push("sout_rel_dtack", 1);
      start(8'h7A, 1'b0, 1'b1, 1'b0);
      clr_mon();
      wait_ack(10, lat);
      sb_check(lat);
      sb_check(n_wr_hi);
      sb_check(wr);
      end_cycle();
      txe_n = 1'b1;
      sb_check(dtack_n);

      // Interrupt acknowledge at a RAM-looking address: autovector only.
      sb_push("iack_lat", 2);
      sb_push("iack_vpa", 0);
      sb_push("iack_dtack", 1);
      sb_push("iack_ceram_lo", 0);
      sb_push("iack_rel_vpa", 1);
      start(8'h80, 1'b1, 1'b1, 1'b1);
      clr_mon();
      wait_ack(8, lat);
      sb_check(lat);
      sb_check(vpa_n);
      sb_check(dtack_n);
      sb_check(n_ceram_lo);
      end_cycle();
      sb_check(vpa_n);

      // Abort of a ROM cycle during wait states: no acknowledge leaks out.
      sb_push("abort_cerom_on", 0);
      sb_push("abort_dtack_lo", 0);
      sb_push("abort_cerom_off", 1);
      sb_push("abort_busy", 0);
      start(8'h00, 1'b1, 1'b1, 1'b0);
      tick();
      tick();
      sb_check(cerom_n);
      as_n = 1'b1;
      ds_n = 1'b1;
      clr_mon();
      repeat (4) tick();
      sb_check(n_dtack_lo);
      sb_check(cerom_n);
      sb_check(busy);

      // Single-step: cycle parks without timing out until a button edge.
      step_mode = 1'b1;
      sb_push("step_dtack_lo", 0);
      sb_push("step_berr_lo", 0);
      sb_push("step_busy", 1);
      sb_push("step_ceram", 0);
      sb_push("step_ack_within_4", 1);
      start(8'h80, 1'b1, 1'b1, 1'b0);
      clr_mon();
      repeat (200) tick();
      sb_check(n_dtack_lo);
      sb_check(n_berr_lo);
      sb_check(busy);
      sb_check(ceram_n);
      step_btn = 1'b1;
      tick();
      step_btn = 1'b0;
      wait_ack(3, lat);
      sb_check((lat > 0) && (lat + 1 <= 4));
      end_cycle();

      // Press while idle is ignored; then reset while parked in STEP.
      sb_push("early_press_dtack_lo", 0);
      sb_push("pre_reset_ceram", 0);
      sb_push("mid_reset_ceram", 1);
      sb_push("mid_reset_busy", 0);
      sb_push("mid_reset_dtack", 1);
      sb_push("post_reset_busy", 0);
      step_btn = 1'b1;
      tick();
      step_btn = 1'b0;
      tick();
      tick();
      start(8'h80, 1'b1, 1'b1, 1'b0);
      clr_mon();
      repeat (20) tick();
      sb_check(n_dtack_lo);
      sb_check(ceram_n);
      #2;
      reset = 1'b1;
      #1;
      sb_check(ceram_n);
      sb_check(busy);
      sb_check(dtack_n);
      @(negedge clk);
      reset = 1'b0;
      as_n = 1'b1;
      ds_n = 1'b1;
      step_mode = 1'b0;
      tick();
      sb_check(busy);

      check_val("sb_leftover", sb_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
